// File: rtl/mc_controller.sv
// Multicycle control unit.
// A 12-state Moore FSM sequences fetch, decode and execute for lw, sw, R-type, beq, addi and j.
// It also decodes alucontrol from the internal aluop and the funct field.
// Ports:
//   clk, reset            - system clock; synchronous active-high reset
//   op, funct             - instruction[31:26] and instruction[5:0]
//   zero                  - ALU zero flag, used by the branch enable
//   pcen, memwrite, irwrite, regwrite - write enables
//   alusrca, iord, memtoreg, regdst   - 1-bit mux selects
//   alusrcb, pcsrc        - 2-bit mux selects
//   alucontrol            - ALU operation
//   illegal               - one-cycle pulse in DECODE for an unsupported opcode
//   state                 - current FSM state code
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e     state_q, state_d, dec_state;
  logic       pcwrite, branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // op is only looked at in DECODE and MEMADR; every other state has a fixed successor.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // During reset the selects show the FETCH decode, but every enable is held low.
  assign dec_state = reset ? StFetch : state_q;

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    case (dec_state)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      StDecode: begin
        alusrcb = 2'b11;
        illegal = !(op inside {OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ});
      end
      StMemAdr, StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StRtypeWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiWb: regwrite = 1'b1;
      StJEx: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller.
// A table of instructions carries hand-written state sequences; a small model gives the expected
// per-state outputs, which are queued at drive time and compared at each falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } exp_t;

  typedef struct {
    string           name;
    logic [5:0]      op;
    logic [5:0]      funct;
    logic            zero;
    int              n;
    logic [4:0][3:0] seq;
    bit              scramble;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[$];
  int    tests = 0;
  int    fails = 0;

  // Expected outputs for a given state, written from the per-state control table.
  function automatic exp_t model(input logic [3:0] st, input logic [5:0] o,
                                 input logic [5:0] f, input logic z, input logic rst);
    exp_t e;
    logic [3:0] d;
    e = '0;
    e.state = st;
    e.alucontrol = 3'b010;
    d = rst ? 4'd0 : st;
    case (d)
      4'd0: begin e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
      4'd1: begin
        e.alusrcb = 2'b11;
        e.illegal = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                      o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
      end
      4'd2, 4'd9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd3: e.iord = 1'b1;
      4'd4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      4'd5: begin e.iord = 1'b1; e.memwrite = 1'b1; end
      4'd6: begin
        e.alusrca = 1'b1;
        case (f)
          6'b100000: e.alucontrol = 3'b010;
          6'b100010: e.alucontrol = 3'b110;
          6'b100100: e.alucontrol = 3'b000;
          6'b100101: e.alucontrol = 3'b001;
          6'b101010: e.alucontrol = 3'b111;
          default:   e.alucontrol = 3'b010;
        endcase
      end
      4'd7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      4'd8: begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.pcen = z; end
      4'd10: e.regwrite = 1'b1;
      4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      e.pcen = 1'b0; e.memwrite = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0; e.illegal = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [4:0][3:0] mkseq(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c, input logic [3:0] d,
                                            input logic [3:0] e);
    return {e, d, c, b, a};
  endfunction

  task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int n, input logic [4:0][3:0] s, input bit scr);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.n = n; v.seq = s; v.scramble = scr;
    vecs.push_back(v);
  endtask

  task automatic expect_cycle(input string name, input logic [3:0] st, input logic rst);
    exp_q.push_back(model(st, op, funct, zero, rst));
    name_q.push_back(name);
  endtask

  task automatic run_vec(input vec_t v);
    op = v.op; funct = v.funct; zero = v.zero;
    for (int i = 0; i < v.n; i++) expect_cycle($sformatf("%s[%0d]", v.name, i), v.seq[i], 1'b0);
    for (int i = 0; i < v.n; i++) begin
      @(posedge clk); #1;
      // op is ignored outside DECODE/MEMADR, so garbage here must not change the sequence
      if (v.scramble && i == 1) op = 6'b111111;
    end
  endtask

  always @(negedge clk) begin
    exp_t  e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.state = state; a.pcen = pcen; a.memwrite = memwrite; a.irwrite = irwrite;
      a.regwrite = regwrite; a.alusrca = alusrca; a.iord = iord; a.memtoreg = memtoreg;
      a.regdst = regdst; a.alusrcb = alusrcb; a.pcsrc = pcsrc; a.alucontrol = alucontrol;
      a.illegal = illegal;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got state=%0d pcen=%b mw=%b irw=%b rw=%b asa=%b iord=%b m2r=%b rd=%b asb=%b pcs=%b alu=%b ill=%b; expected state=%0d pcen=%b mw=%b irw=%b rw=%b asa=%b iord=%b m2r=%b rd=%b asb=%b pcs=%b alu=%b ill=%b",
                 n, a.state, a.pcen, a.memwrite, a.irwrite, a.regwrite, a.alusrca, a.iord,
                 a.memtoreg, a.regdst, a.alusrcb, a.pcsrc, a.alucontrol, a.illegal,
                 e.state, e.pcen, e.memwrite, e.irwrite, e.regwrite, e.alusrca, e.iord,
                 e.memtoreg, e.regdst, e.alusrcb, e.pcsrc, e.alucontrol, e.illegal);
      end
    end
  end

  initial begin
    add("lw",       6'b100011, 6'b000000, 1'b0, 5, mkseq(0, 1, 2, 3, 4),  1'b0);
    add("sw",       6'b101011, 6'b000000, 1'b0, 4, mkseq(0, 1, 2, 5, 0),  1'b0);
    add("add",      6'b000000, 6'b100000, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("sub",      6'b000000, 6'b100010, 1'b1, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("and",      6'b000000, 6'b100100, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("or",       6'b000000, 6'b100101, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("slt",      6'b000000, 6'b101010, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("rt_unk",   6'b000000, 6'b111111, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b0);
    add("beq_taken",6'b000100, 6'b000000, 1'b1, 3, mkseq(0, 1, 8, 0, 0),  1'b0);
    add("beq_not",  6'b000100, 6'b000000, 1'b0, 3, mkseq(0, 1, 8, 0, 0),  1'b0);
    add("addi",     6'b001000, 6'b000000, 1'b0, 4, mkseq(0, 1, 9, 10, 0), 1'b0);
    add("j",        6'b000010, 6'b000000, 1'b0, 3, mkseq(0, 1, 11, 0, 0), 1'b0);
    add("ill_3f",   6'b111111, 6'b000000, 1'b0, 2, mkseq(0, 1, 0, 0, 0),  1'b0);
    add("ill_01",   6'b000001, 6'b000000, 1'b1, 2, mkseq(0, 1, 0, 0, 0),  1'b0);
    add("sub_scr",  6'b000000, 6'b100010, 1'b0, 4, mkseq(0, 1, 6, 7, 0),  1'b1);
    add("beq_scr",  6'b000100, 6'b000000, 1'b1, 3, mkseq(0, 1, 8, 0, 0),  1'b1);
    add("lw2",      6'b100011, 6'b000000, 1'b1, 5, mkseq(0, 1, 2, 3, 4),  1'b0);

    op = 6'b000000; funct = 6'b000000; zero = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    expect_cycle("reset_hold", 4'd0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset arriving mid-lw, while in MEMRD.
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    expect_cycle("rst_lw[0]", 4'd0, 1'b0);
    expect_cycle("rst_lw[1]", 4'd1, 1'b0);
    expect_cycle("rst_lw[2]", 4'd2, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    expect_cycle("rst_in_memrd", 4'd3, 1'b1);
    @(posedge clk); #1;
    expect_cycle("rst_to_fetch", 4'd0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(vecs[0]);

    op = 6'b000000;
    expect_cycle("idle_fetch", 4'd0, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port op  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port funct  input  6  instruction[5:0] from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag, same cycle.
REQ-006 SHALL have outputs pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  output  1 each  datapath enables and mux selects.
REQ-007 SHALL have outputs alusrcb, pcsrc  output  2 each  ALU B-mux select and PC-mux select.
REQ-008 SHALL have output alucontrol  output  3  ALU operation.
REQ-009 SHALL have output illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have output state  output  4  current FSM state code, for debug and bench.

Function
REQ-011 SHALL be a Moore FSM with 12 states and fixed codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE by op: 100011 (lw) or 101011 (sw) ->MEMADR; 000000 ->RTYPEEX; 000100 ->BEQEX; 001000 ->ADDIEX; 000010 ->JEX; any other op ->FETCH with illegal=1 for that DECODE cycle only.
REQ-014 SHALL transition MEMADR->MEMRD if op=lw, else MEMWR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-015 SHALL transition MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX ->FETCH.
REQ-016 SHALL sample op only in DECODE and MEMADR; op changes in other states SHALL not alter sequencing.
REQ-017 SHALL drive in FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-018 SHALL drive in DECODE: alusrca=0, alusrcb=11, aluop=00; in MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-019 SHALL drive in MEMRD: iord=1; in MEMWR: iord=1, memwrite=1; in MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-020 SHALL drive in RTYPEEX: alusrca=1, alusrcb=00, aluop=10; in RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-021 SHALL drive in BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; in ADDIWB: regdst=0, memtoreg=0, regwrite=1; in JEX: pcsrc=10, pcwrite=1.
REQ-022 SHALL drive every control signal not listed for a state to 0 (all-zero vectors).
REQ-023 SHALL compute pcen = pcwrite OR (branch AND zero), combinationally in the same cycle.
REQ-024 SHALL decode alucontrol combinationally: aluop 00->010; 01->110; 10 with funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010; aluop 11->010.
REQ-025 SHALL give per-instruction latency: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-026 SHALL load state=FETCH on any rising clk edge with reset=1, including mid-instruction from any state.
REQ-027 SHALL force pcen, memwrite, irwrite, regwrite and illegal to 0 while reset=1; mux selects and alucontrol SHALL follow the FETCH decode.
REQ-028 SHALL begin a normal FETCH cycle on the first rising edge with reset=0 after reset.

Verification
REQ-029 SHALL verify lw: op=100011 -> states 0,1,2,3,4,0; memwrite=0 throughout; iord=1 in state 3; regwrite=1 and memtoreg=1 only in state 4.
REQ-030 SHALL verify sw: op=101011 -> states 0,1,2,5,0; memwrite=1 and iord=1 only in state 5; regwrite never 1.
REQ-031 SHALL verify beq: in BEQEX, zero=1 -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0; next state 0.
REQ-032 SHALL verify R-type: op=000000 with funct 100000/100010/100100/100101/101010 -> alucontrol in RTYPEEX = 010/110/000/001/111; regdst=1 and regwrite=1 in RTYPEWB.
REQ-033 SHALL verify illegal op=111111 -> illegal=1 for exactly one cycle in DECODE, next state 0, no write enable asserted.
REQ-034 SHALL verify reset asserted in MEMRD -> state=0 on next edge; write enables 0 while reset=1; after release the first FETCH shows irwrite=1 and pcen=1.
